rx_demux: RTL and testbench

Receive-side counterpart of the transmit multiplexer. Pops the three-byte frames (header, data MSB, data LSB) from the rx FIFO, reassembles the 16-bit word and presents it on the output channel named in the header with a valid/ack handshake. It sits between the rx FIFO read port and the four channel consumers.

---
 rtl/txrx_pkg.sv | 47 ++++
 rtl/rx_demux_if.sv | 29 ++
 rtl/sat_counter.sv | 22 ++
 rtl/rx_demux.sv | 116 +++++++++++
 tb/tb_rx_demux.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/txrx_pkg.sv
// Shared tx/rx framing definitions: channel count, header layout, byte order,
// rx state encoding and small helpers for header checks and word assembly.
package txrx_pkg;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned CNT_W   = 8;

  // Header bits [7:2] are reserved and must be zero.
  localparam logic [BYTE_W-1:0] HDR_RSVD_MASK = 8'hFC;

  // Payload byte order on the wire: high byte travels first.
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    RX_HDR     = 2'd0,
    RX_MSB     = 2'd1,
    RX_LSB     = 2'd2,
    RX_DELIVER = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } rx_word_t;

  function automatic logic hdr_ok(input logic [BYTE_W-1:0] b);
    return (b & HDR_RSVD_MASK) == BYTE_W'(0);
  endfunction

  // Rebuild a word from the first and second payload bytes seen on the wire.
  function automatic rx_word_t join_bytes(input logic [BYTE_W-1:0] first,
                                          input logic [BYTE_W-1:0] second);
    rx_word_t w;
    if (MSB_FIRST) begin
      w.hi = first;
      w.lo = second;
    end else begin
      w.hi = second;
      w.lo = first;
    end
    return w;
  endfunction

endpackage

// File: rtl/rx_demux_if.sv
// rx_demux bus bundle: rx FIFO read port plus the four channel outputs.
//   rempty/rdata/rinc : FWFT FIFO read side
//   out_0..out_3      : per-channel reassembled words
//   valid/ack         : per-channel handshake
// master = demux side, slave = FIFO/consumer side.
interface rx_demux_if;
  import txrx_pkg::*;

  logic                rempty;
  logic [BYTE_W-1:0]   rdata;
  logic                rinc;
  logic [WORD_W-1:0]   out_0;
  logic [WORD_W-1:0]   out_1;
  logic [WORD_W-1:0]   out_2;
  logic [WORD_W-1:0]   out_3;
  logic [NUM_CH-1:0]   valid;
  logic [NUM_CH-1:0]   ack;

  modport master (
    input  rempty, rdata, ack,
    output rinc, out_0, out_1, out_2, out_3, valid
  );

  modport slave (
    output rempty, rdata, ack,
    input  rinc, out_0, out_1, out_2, out_3, valid
  );

endinterface

// File: rtl/sat_counter.sv
// 8-bit counter with increment enable that sticks at its maximum value.
//   clk, rst_n : clock, async active-low reset (clears to 0)
//   inc        : increment request
//   count      : current value
module sat_counter
  import txrx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rx_demux.sv
// Receive demultiplexer: pops 3-byte frames (header, MSB, LSB) from the rx
// FIFO, rebuilds the 16-bit word and hands it to the addressed channel with a
// valid/ack handshake. One word in flight at a time (head-of-line blocking).
//   clk, rst_n  : clock, async active-low reset
//   bus         : rx_demux_if.master (FIFO read port + channel outputs)
//   hdr_err_cnt : rejected header count
// Optional build macro RX_DEMUX_HDR_ERR_CNT_EN enables the saturating
// header-error counter; otherwise hdr_err_cnt is tied to 0.
module rx_demux
  import txrx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  rx_demux_if.master       bus,
  output logic [CNT_W-1:0] hdr_err_cnt
);

  rx_state_e              state_q, state_d;
  logic [CH_W-1:0]        ch_q;
  logic [BYTE_W-1:0]      staged_q;
  rx_word_t [NUM_CH-1:0]  out_q;
  logic [NUM_CH-1:0]      valid_q;

  logic pop;
  logic latch_ch;
  logic hdr_rej;
  logic latch_msb;
  logic word_done;
  logic ack_hit;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RX_HDR;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_HDR:     if (latch_ch)  state_d = RX_MSB;
      RX_MSB:     if (latch_msb) state_d = RX_LSB;
      RX_LSB:     if (word_done) state_d = RX_DELIVER;
      RX_DELIVER: if (ack_hit)   state_d = RX_HDR;
      default:                   state_d = RX_HDR;
    endcase
  end

  // Pop and datapath strobes; rst_n gating keeps rinc low during reset.
  always_comb begin
    pop       = 1'b0;
    latch_ch  = 1'b0;
    hdr_rej   = 1'b0;
    latch_msb = 1'b0;
    word_done = 1'b0;
    ack_hit   = 1'b0;
    case (state_q)
      RX_HDR: begin
        pop      = rst_n & ~bus.rempty;
        latch_ch = pop & hdr_ok(bus.rdata);
        hdr_rej  = pop & ~hdr_ok(bus.rdata);
      end
      RX_MSB: begin
        pop       = rst_n & ~bus.rempty;
        latch_msb = pop;
      end
      RX_LSB: begin
        pop       = rst_n & ~bus.rempty;
        word_done = pop;
      end
      RX_DELIVER: ack_hit = bus.ack[ch_q];
      default: ;
    endcase
  end

  assign bus.rinc = pop;

  // Channel, staging and per-channel output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q     <= '0;
      staged_q <= '0;
      out_q    <= '0;
      valid_q  <= '0;
    end else begin
      if (latch_ch)  ch_q     <= bus.rdata[CH_W-1:0];
      if (latch_msb) staged_q <= bus.rdata;
      if (word_done) begin
        out_q[ch_q]   <= join_bytes(staged_q, bus.rdata);
        valid_q[ch_q] <= 1'b1;
      end
      if (ack_hit) valid_q[ch_q] <= 1'b0;
    end
  end

  assign bus.out_0 = out_q[0];
  assign bus.out_1 = out_q[1];
  assign bus.out_2 = out_q[2];
  assign bus.out_3 = out_q[3];
  assign bus.valid = valid_q;

`ifdef RX_DEMUX_HDR_ERR_CNT_EN
  sat_counter u_hdr_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hdr_rej),
    .count (hdr_err_cnt)
  );
`else
  // Rejected headers are still dropped; only the count is absent.
  logic unused_hdr_rej;
  assign unused_hdr_rej = hdr_rej;
  assign hdr_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_rx_demux.sv
// Directed bench for rx_demux: FWFT byte FIFO model feeding the DUT, checks
// sampled on the falling clock edge against hand-computed values.
module tb_rx_demux;
  import txrx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] hdr_err_cnt;

  rx_demux_if bus();

  rx_demux dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .hdr_err_cnt (hdr_err_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  bit         stall = 1'b0;
  int         pop_cnt = 0;
  int         total = 0;
  int         bad = 0;

  function automatic void refresh();
    bus.rempty = stall || (q.size() == 0);
    bus.rdata  = (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    refresh();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // FIFO model: pop on each rising edge where rinc was high.
  initial begin
    bit do_pop;
    forever begin
      @(posedge clk);
      do_pop = bus.rinc;
      #1;
      if (do_pop && q.size() != 0) begin
        void'(q.pop_front());
        pop_cnt++;
      end
      refresh();
    end
  end

  initial begin
    logic [7:0] err_exp;
    bit         saw_valid;
    int         p0;

    bus.ack = '0;
    refresh();
    tick(2);

    // Reset state, bytes already waiting.
    push(8'h02); push(8'hAB); push(8'hCD);
    #1;
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_out",   32'({bus.out_0, bus.out_1}), 32'h0);
    chk("rst_cnt",   32'(hdr_err_cnt), 32'h0);
    chk("rst_rinc",  32'(bus.rinc), 32'h0);

    // Frame 02 AB CD, no ack.
    @(negedge clk); rst_n = 1'b1;
    tick(3);
    chk("f1_valid", 32'(bus.valid), 32'h4);
    chk("f1_out2",  32'(bus.out_2), 32'hABCD);
    chk("f1_rinc",  32'(bus.rinc), 32'h0);
    bus.ack = 4'b1011;
    tick(2);
    chk("f1_hold_valid", 32'(bus.valid), 32'h4);
    chk("f1_pops",       32'(pop_cnt), 32'd3);
    bus.ack = 4'b0100;
    tick(1);
    chk("f1_ack_valid", 32'(bus.valid), 32'h0);

    // Back-to-back frames with ack held high.
    bus.ack = 4'hF;
    push(8'h00); push(8'h12); push(8'h34);
    push(8'h03); push(8'h56); push(8'h78);
    tick(3);
    chk("b2b_valid0", 32'(bus.valid), 32'h1);
    chk("b2b_out0",   32'(bus.out_0), 32'h1234);
    tick(1);
    chk("b2b_clr0", 32'(bus.valid), 32'h0);
    tick(3);
    chk("b2b_valid3", 32'(bus.valid), 32'h8);
    chk("b2b_out3",   32'(bus.out_3), 32'h5678);
    chk("b2b_out0_keep", 32'(bus.out_0), 32'h1234);
    chk("b2b_pops",   32'(pop_cnt), 32'd9);
    tick(1);
    chk("b2b_clr3", 32'(bus.valid), 32'h0);

    // FIFO empty for two cycles between MSB and LSB.
    push(8'h00); push(8'h12);
    tick(2);
    stall = 1'b1;
    push(8'h34);
    p0 = pop_cnt;
    tick(2);
    chk("stall_valid", 32'(bus.valid), 32'h0);
    chk("stall_pops",  32'(pop_cnt - p0), 32'd0);
    chk("stall_rinc",  32'(bus.rinc), 32'h0);
    stall = 1'b0;
    refresh();
    tick(1);
    chk("stall_done", 32'(bus.valid), 32'h1);
    chk("stall_out0", 32'(bus.out_0), 32'h1234);
    tick(1);

    // Bad header then a good frame.
`ifdef RX_DEMUX_HDR_ERR_CNT_EN
    err_exp = 8'd1;
`else
    err_exp = 8'd0;
`endif
    push(8'h05); push(8'h01); push(8'hAA); push(8'hBB);
    tick(1);
    chk("rej_cnt",   32'(hdr_err_cnt), 32'(err_exp));
    chk("rej_valid", 32'(bus.valid), 32'h0);
    tick(3);
    chk("rej_valid1", 32'(bus.valid), 32'h2);
    chk("rej_out1",   32'(bus.out_1), 32'hAABB);
    tick(1);

    // 300 reserved-bit bytes: counter saturates, nothing delivered.
    saw_valid = 1'b0;
    for (int i = 0; i < 300; i++) push(8'hFF);
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (bus.valid != 4'h0) saw_valid = 1'b1;
      if (i == 199) begin
`ifdef RX_DEMUX_HDR_ERR_CNT_EN
        chk("sat_mid", 32'(hdr_err_cnt), 32'd201);
`else
        chk("sat_mid", 32'(hdr_err_cnt), 32'd0);
`endif
      end
    end
`ifdef RX_DEMUX_HDR_ERR_CNT_EN
    chk("sat_cnt", 32'(hdr_err_cnt), 32'd255);
`else
    chk("sat_cnt", 32'(hdr_err_cnt), 32'd0);
`endif
    chk("sat_novalid", 32'(saw_valid), 32'h0);
    chk("sat_drained", 32'(q.size()), 32'd0);

    // Reset after MSB of 01 11 22; leftover 22 is rejected, then 01 33 44.
    push(8'h01); push(8'h11); push(8'h22);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.valid), 32'h0);
    chk("mid_rst_out1",  32'(bus.out_1), 32'h0);
    chk("mid_rst_cnt",   32'(hdr_err_cnt), 32'h0);
    chk("mid_rst_rinc",  32'(bus.rinc), 32'h0);
    push(8'h01); push(8'h33); push(8'h44);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("resync_cnt", 32'(hdr_err_cnt), 32'(err_exp));
    tick(3);
    chk("resync_valid", 32'(bus.valid), 32'h2);
    chk("resync_out1",  32'(bus.out_1), 32'h3344);
    tick(1);
    chk("resync_clr", 32'(bus.valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
